fir_level_meter: RTL
====================

Name: fir_level_meter

Overview:
- Measurement stage placed directly downstream of the FIR filter; consumes its o_valid/o_data stream.
- Over each block of WINDOW valid samples, reports:
  - the peak absolute value;
  - the mean square, as a power estimate;
  - a threshold flag.
- Used for in-system passband/stopband checks. Also the monitoring point for filter output level.

Parameters:
- WIDTH, 16: sample width, signed two's complement; matches FIR WIDTH.
- LOG2_WINDOW, 6: window length is WINDOW = 2**LOG2_WINDOW valid samples; legal range 1..12.
- THRESH, 67108864: unsigned mean-square threshold (2*WIDTH bits) for o_above.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  sample strobe, from FIR o_valid.
- i_data  in  WIDTH  signed sample, from FIR o_data.
- i_clear  in  1  synchronous restart; discards the partial window.
- o_valid  out  1  one-cycle pulse; the result outputs are updated in that cycle.
- o_peak  out  WIDTH  unsigned max |x| over the window; |-2**(WIDTH-1)| = 2**(WIDTH-1) fits without saturation.
- o_mean_sq  out  2*WIDTH  unsigned (sum of x*x over the window) >> LOG2_WINDOW; truncating.
- o_above  out  1  o_mean_sq >= THRESH; registered with o_mean_sq.
- o_busy  out  1  high while a window is partially accumulated (state ACCUM).

Behaviour:
- Reset (rst low, async): all outputs 0, all counters and accumulators 0, all pipeline valid tags 0, state IDLE.
- Pipeline:
  - S1 registers |x| and x*x (2*WIDTH unsigned) tagged with i_valid.
  - S2 accumulates: sum register is 2*WIDTH+LOG2_WINDOW bits, so overflow is impossible. Peak register is WIDTH bits. Sample counter is LOG2_WINDOW bits.
  - Output register follows S2.
- Latency: o_valid rises at the second rising edge after the edge that captured the WINDOW-th valid sample of the window.
- Gaps: cycles with i_valid low are ignored entirely; they neither advance the count nor insert zeros. Arbitrary gap patterns give the same result as back-to-back input.
- State machine:
  - IDLE: no samples accumulated. First valid sample reaching S2 → ACCUM, count=1, sum=x*x, peak=|x|.
  - ACCUM: each S2-valid sample adds x*x to sum, peak=max(peak,|x|), count+=1.
  - When the sample completing count==WINDOW enters S2:
    - results are registered to the outputs next cycle with o_valid=1;
    - sum, peak and count restart from that cycle;
    - state returns to IDLE, or stays in ACCUM if another S2-valid sample arrives the same cycle. That sample seeds the new window; no sample is lost.
- Back-to-back windows: continuous i_valid yields one o_valid pulse every WINDOW cycles, with no dead cycle.
- Between pulses, o_peak/o_mean_sq/o_above hold the last window's values; o_valid is 0.
- i_clear (synchronous, sampled on rising edge):
  - Flushes the S1/S2 valid tags, sum, peak and count; state → IDLE.
  - An i_valid sample in the same cycle is discarded.
  - A window whose result has not yet been registered to the outputs is cancelled; no o_valid for it.
  - Result outputs hold their previous values.
  - An o_valid already high in the clear cycle completes normally.
- Mid-window reset behaves like a full reset; outputs return to 0.
- Arithmetic:
  - |x| and x*x are computed in WIDTH+1 / 2*WIDTH unsigned without sign wrap.
  - o_mean_sq is the truncated bits [2*WIDTH+LOG2_WINDOW-1 : LOG2_WINDOW] of sum; its maximum is 2**(2*WIDTH-2), so it never exceeds the width.
- o_busy equals (state == ACCUM), registered.

Test Plan:
- Constant 16384 for 64 back-to-back samples after reset → one o_valid; o_peak=16384, o_mean_sq=268435456, o_above=1. Pulse at the 2nd edge after the 64th sample edge.
- Constant -32768 ×64 → o_peak=32768, o_mean_sq=1073741824; alternating +1000/-1000 ×64 → o_peak=1000, o_mean_sq=1000000, o_above=0.
- Same +1000/-1000 stream with i_valid toggling 1-0-0-1 pseudo-randomly → identical results to the back-to-back case; o_valid only after 64 valid samples.
- 128 continuous samples: first 64 = 100, next 64 = 2000 → two pulses 64 cycles apart, with o_mean_sq=10000 then 4000000. Outputs hold between pulses.
- i_clear after 40 samples of 5000, then 64 samples of 300 → single pulse, o_peak=300, o_mean_sq=90000. Clear asserted together with i_valid drops that sample.
- rst low for 1 cycle at sample 30 (asynchronous, mid-cycle) → outputs 0 immediately, o_busy=0. The next 64 samples produce a correct fresh window.

Source files
------------

// File: rtl/fir_level_meter.sv
// -----------------------------------------------------------------------------
// fir_level_meter
//
// Level meter placed directly after the FIR filter. It collects blocks of
// WINDOW = 2**LOG2_WINDOW valid samples and reports three results per block:
// the peak absolute value, the mean square (a power estimate), and a flag
// that is set when the mean square reaches THRESH.
//
// Pipeline:
//   S1  registers |x| and x*x, tagged with the sample strobe.
//   S2  accumulates the sum of squares, the running peak and the sample count.
//       A small IDLE/ACCUM state machine tracks whether a window is open.
//   OUT registers the finished window's results and pulses o_valid.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   i_valid    sample strobe (FIR o_valid)
//   i_data     signed sample (FIR o_data)
//   i_clear    synchronous restart; drops the partial window and any
//              result that has not reached the outputs yet
//   o_valid    one-cycle pulse when new results are presented
//   o_peak     max |x| over the window (unsigned)
//   o_mean_sq  (sum of x*x over the window) >> LOG2_WINDOW, truncated
//   o_above    o_mean_sq >= THRESH, registered together with o_mean_sq
//   o_busy     high while a window is partially accumulated
// -----------------------------------------------------------------------------
module fir_level_meter #(
  parameter int                WIDTH       = 16,
  parameter int                LOG2_WINDOW = 6,
  parameter longint unsigned   THRESH      = 64'd67108864
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_clear,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_peak,
  output logic [2*WIDTH-1:0]      o_mean_sq,
  output logic                    o_above,
  output logic                    o_busy
);

  localparam int SQ_W  = 2 * WIDTH;
  // Enough headroom for WINDOW full-scale squares, so the sum never wraps.
  localparam int SUM_W = SQ_W + LOG2_WINDOW;

  // The counter holds 0..WINDOW-1; the sample that finds it at all-ones is
  // the one completing the window.
  localparam logic [LOG2_WINDOW-1:0] CNT_LAST = '1;
  localparam logic [LOG2_WINDOW-1:0] CNT_ONE  = LOG2_WINDOW'(1);
  localparam logic [SQ_W-1:0]        THRESH_W = SQ_W'(THRESH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // S1: magnitude and square of the incoming sample
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mag;
  logic [SQ_W-1:0]  sq;

  // NOTE: always_comb assigns every output on every path (here by a single
  // unconditional expression, elsewhere by defaults first) so no latch forms.
  always_comb begin
    // WIDTH-bit two's complement negation is exact when read as unsigned:
    // the most negative value maps to 2**(WIDTH-1), which fits.
    mag = i_data[WIDTH-1] ? (~unsigned'(i_data) + {{(WIDTH-1){1'b0}}, 1'b1})
                          : unsigned'(i_data);
    sq  = {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, mag};
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_mag_q;
  logic [SQ_W-1:0]  s1_sq_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_sq_q    <= '0;
    end else begin
      // A sample presented together with i_clear is dropped here.
      s1_valid_q <= i_valid & ~i_clear;
      if (i_valid) begin
        s1_mag_q <= mag;
        s1_sq_q  <= sq;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: window accumulation
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [WIDTH-1:0]       peak_q, peak_d;
  logic [LOG2_WINDOW-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;

  logic                   restart;
  logic [SUM_W-1:0]       base_sum;
  logic [WIDTH-1:0]       base_peak;
  logic [LOG2_WINDOW-1:0] base_cnt;

  always_comb begin
    // A window restarts from zero either when none is open or in the cycle
    // right after one completed (done_q): sum_q/peak_q then still hold the
    // finished results for the output stage, but must not be extended.
    restart   = (state_q == ST_IDLE) || done_q;
    base_sum  = restart ? '0 : sum_q;
    base_peak = restart ? '0 : peak_q;
    base_cnt  = restart ? '0 : cnt_q;

    state_d = state_q;
    sum_d   = sum_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (restart) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      peak_d  = '0;
      cnt_d   = '0;
    end

    if (s1_valid_q) begin
      // A sample arriving in the restart cycle seeds the next window.
      state_d = ST_ACCUM;
      sum_d   = base_sum + SUM_W'(s1_sq_q);
      peak_d  = (s1_mag_q > base_peak) ? s1_mag_q : base_peak;
      cnt_d   = base_cnt + CNT_ONE;
      // Completing sample: the counter wraps to zero and done_q hands the
      // totals to the output stage next cycle.
      done_d  = !restart && (cnt_q == CNT_LAST);
    end

    if (i_clear) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      peak_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      peak_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [SQ_W-1:0] mean_sq;
  logic            publish;

  always_comb begin
    // Division by WINDOW is a plain truncating shift; the top bits can never
    // be set because the mean of squares is at most 2**(2*WIDTH-2).
    mean_sq = sum_q[SUM_W-1:LOG2_WINDOW];
    // A completed window whose results meet i_clear at this edge is cancelled.
    publish = done_q & ~i_clear;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid   <= 1'b0;
      o_peak    <= '0;
      o_mean_sq <= '0;
      o_above   <= 1'b0;
    end else begin
      o_valid <= publish;
      // Results hold their last values between pulses and across a clear.
      if (publish) begin
        o_peak    <= peak_q;
        o_mean_sq <= mean_sq;
        o_above   <= (mean_sq >= THRESH_W);
      end
    end
  end

  // state_q is itself a register, so o_busy is glitch-free.
  assign o_busy = (state_q == ST_ACCUM);

endmodule
